// File: rtl/traffic_pkg.sv
// Shared encodings for the NS/EW traffic-light controller.
// TRAFFIC_NIGHT_FLASH_EN adds the FLASH state encoding.
package traffic_pkg;

    localparam logic [2:0] S_ALLRED_A  = 3'd0;
    localparam logic [2:0] S_NS_GREEN  = 3'd1;
    localparam logic [2:0] S_NS_YELLOW = 3'd2;
    localparam logic [2:0] S_ALLRED_B  = 3'd3;
    localparam logic [2:0] S_EW_GREEN  = 3'd4;
    localparam logic [2:0] S_EW_YELLOW = 3'd5;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    localparam logic [2:0] S_FLASH     = 3'd6;
`endif

    typedef enum logic [2:0] {
        ALLRED_A  = S_ALLRED_A,
        NS_GREEN  = S_NS_GREEN,
        NS_YELLOW = S_NS_YELLOW,
        ALLRED_B  = S_ALLRED_B,
        EW_GREEN  = S_EW_GREEN,
        EW_YELLOW = S_EW_YELLOW
`ifdef TRAFFIC_NIGHT_FLASH_EN
        , FLASH   = S_FLASH
`endif
    } state_t;

    // {red,yellow,green}
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    function automatic state_t next_phase(input state_t s);
        case (s)
            ALLRED_A:  next_phase = NS_GREEN;
            NS_GREEN:  next_phase = NS_YELLOW;
            NS_YELLOW: next_phase = ALLRED_B;
            ALLRED_B:  next_phase = EW_GREEN;
            EW_GREEN:  next_phase = EW_YELLOW;
            default:   next_phase = ALLRED_A;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle tick every CLK_HZ clock cycles.
module tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_1s
);

    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);

    logic [DIV_W-1:0] div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div <= '0;
        else if (div == DIV_MAX)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    assign tick_1s = (div == DIV_MAX);

endmodule

// File: rtl/traffic_ctrl.sv
// Two-direction traffic-light FSM with countdowns and pedestrian green shortening.
// TRAFFIC_NIGHT_FLASH_EN adds the night input and a flashing-yellow FLASH state.
module traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int T_GREEN   = 20,
    parameter int T_YELLOW  = 3,
    parameter int T_ALLRED  = 1,
    parameter int T_PED_MIN = 5,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ped_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
    input  logic             night,
`endif
    output logic [2:0]       light_ns,
    output logic [2:0]       light_ew,
    output logic [CNT_W-1:0] cnt_ns,
    output logic [CNT_W-1:0] cnt_ew,
    output logic             ped_wait,
    output logic             tick_1s
);

    localparam logic [CNT_W-1:0] D_GREEN  = CNT_W'(T_GREEN);
    localparam logic [CNT_W-1:0] D_YELLOW = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] D_ALLRED = CNT_W'(T_ALLRED);
    localparam logic [CNT_W-1:0] D_PED    = CNT_W'(T_PED_MIN);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic             ped_q, ped_d;
    logic             flash_q, flash_d;
    logic [CNT_W-1:0] base;
    logic             is_green;

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_1s (tick_1s)
    );

    function automatic logic [CNT_W-1:0] phase_len(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   phase_len = D_GREEN;
            NS_YELLOW, EW_YELLOW: phase_len = D_YELLOW;
            default:              phase_len = D_ALLRED;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALLRED_A;
            phase_q <= D_ALLRED;
            ped_q   <= 1'b0;
            flash_q <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ped_q   <= ped_d;
            flash_q <= flash_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        ped_d    = ped_q | ped_req;
        flash_d  = flash_q;
        is_green = (state_q == NS_GREEN) || (state_q == EW_GREEN);
        base     = tick_1s ? phase_q - ONE : phase_q;

        if (tick_1s && phase_q == ONE) begin
            // Phase end wins over a same-cycle request; a pending request shortens the next green.
            state_d = next_phase(state_q);
            phase_d = phase_len(state_d);
            if ((state_d == NS_GREEN || state_d == EW_GREEN) && ped_d) begin
                phase_d = D_PED;
                ped_d   = 1'b0;
            end
        end else if (is_green) begin
            phase_d = base;
            if (ped_d) begin
                phase_d = (base > D_PED) ? D_PED : base;
                ped_d   = 1'b0;
            end
        end else begin
            phase_d = base;
        end

`ifdef TRAFFIC_NIGHT_FLASH_EN
        if (state_q == FLASH) begin
            ped_d = 1'b0;
            if (!night) begin
                state_d = ALLRED_A;
                phase_d = D_ALLRED;
            end else begin
                state_d = FLASH;
                phase_d = phase_q;
                if (tick_1s)
                    flash_d = ~flash_q;
            end
        end else if (night) begin
            state_d = FLASH;
            phase_d = phase_q;
            ped_d   = 1'b0;
            flash_d = 1'b1;
        end
`endif
    end

    always_comb begin
        light_ns = RED;
        light_ew = RED;
        case (state_q)
            NS_GREEN:  light_ns = GRN;
            NS_YELLOW: light_ns = YEL;
            EW_GREEN:  light_ew = GRN;
            EW_YELLOW: light_ew = YEL;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            FLASH: begin
                light_ns = flash_q ? YEL : OFF;
                light_ew = flash_q ? YEL : OFF;
            end
`endif
            default: ;
        endcase
    end

    // A red direction counts the rest of this phase plus every phase before its own green.
    always_comb begin
        cnt_ns = phase_q;
        cnt_ew = phase_q;
        case (state_q)
            ALLRED_A:  cnt_ew = phase_q + D_GREEN + D_YELLOW + D_ALLRED;
            NS_GREEN:  cnt_ew = phase_q + D_YELLOW + D_ALLRED;
            NS_YELLOW: cnt_ew = phase_q + D_ALLRED;
            ALLRED_B:  cnt_ns = phase_q + D_GREEN + D_YELLOW + D_ALLRED;
            EW_GREEN:  cnt_ns = phase_q + D_YELLOW + D_ALLRED;
            EW_YELLOW: cnt_ns = phase_q + D_ALLRED;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            FLASH: begin
                cnt_ns = '0;
                cnt_ew = '0;
            end
`endif
            default: ;
        endcase
    end

    assign ped_wait = ped_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed self-checking bench for traffic_ctrl with CLK_HZ=10.
// Night-flash vectors run only when TRAFFIC_NIGHT_FLASH_EN is defined.
module tb_traffic_ctrl;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             ped_req;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    logic             night;
`endif
    logic [2:0]       light_ns;
    logic [2:0]       light_ew;
    logic [CNT_W-1:0] cnt_ns;
    logic [CNT_W-1:0] cnt_ew;
    logic             ped_wait;
    logic             tick_1s;

    int n_checks = 0;
    int n_errors = 0;
    logic [CNT_W-1:0] exp_q[$];

    traffic_ctrl #(
        .CLK_HZ    (10),
        .T_GREEN   (20),
        .T_YELLOW  (3),
        .T_ALLRED  (1),
        .T_PED_MIN (5),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ped_req  (ped_req),
`ifdef TRAFFIC_NIGHT_FLASH_EN
        .night    (night),
`endif
        .light_ns (light_ns),
        .light_ew (light_ew),
        .cnt_ns   (cnt_ns),
        .cnt_ew   (cnt_ew),
        .ped_wait (ped_wait),
        .tick_1s  (tick_1s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int n = 0;
        while (!tick_1s && n < 40) begin
            cycle();
            n++;
        end
        if (!tick_1s)
            check("tick_wait", {31'b0, tick_1s}, 32'd1);
    endtask

    task automatic next_sec(input int secs);
        for (int i = 0; i < secs; i++) begin
            wait_tick();
            cycle();
        end
    endtask

    task automatic pulse_ped();
        ped_req = 1'b1;
        cycle();
        ped_req = 1'b0;
    endtask

    task automatic do_reset_release();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic check_first_tick();
        int n = 0;
        while (!tick_1s && n < 40) begin
            cycle();
            n++;
        end
        check("first_tick_cycle", n, 32'd9);
    endtask

    initial begin
        rst_n   = 1'b0;
        ped_req = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
        night   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        do_reset_release();

        // Reset values
        check("rst_light_ns", light_ns, 3'b100);
        check("rst_light_ew", light_ew, 3'b100);
        check("rst_cnt_ns", cnt_ns, 8'd1);
        check("rst_cnt_ew", cnt_ew, 8'd25);
        check("rst_ped_wait", ped_wait, 1'b0);
        check_first_tick();

        // Full cycle with no requests
        cycle();
        check("ns_green_light", light_ns, 3'b001);
        check("ns_green_ew_red", light_ew, 3'b100);
        check("ns_green_cnt_ew", cnt_ew, 8'd24);
        for (int i = 20; i >= 1; i--) exp_q.push_back(CNT_W'(i));
        while (exp_q.size() > 0) begin
            check("ns_green_cnt_ns", cnt_ns, exp_q.pop_front());
            next_sec(1);
        end
        check("ns_yellow_light", light_ns, 3'b010);
        check("ns_yellow_cnt_ns", cnt_ns, 8'd3);
        check("ns_yellow_cnt_ew", cnt_ew, 8'd4);
        next_sec(3);
        check("allred_b_ns", light_ns, 3'b100);
        check("allred_b_ew", light_ew, 3'b100);
        check("allred_b_cnt_ns", cnt_ns, 8'd25);
        check("allred_b_cnt_ew", cnt_ew, 8'd1);
        next_sec(1);
        check("ew_green_light", light_ew, 3'b001);
        check("ew_green_cnt_ew", cnt_ew, 8'd20);
        check("ew_green_cnt_ns", cnt_ns, 8'd24);
        next_sec(20);
        check("ew_yellow_light", light_ew, 3'b010);
        check("ew_yellow_cnt_ns", cnt_ns, 8'd4);
        next_sec(3);
        check("allred_a_cnt_ns", cnt_ns, 8'd1);
        check("allred_a_cnt_ew", cnt_ew, 8'd25);
        next_sec(1);
        check("ns_green2_cnt_ns", cnt_ns, 8'd20);

        // Request at NS green with 15 s left
        next_sec(5);
        check("ped_pre_cnt_ns", cnt_ns, 8'd15);
        pulse_ped();
        check("ped_short_cnt_ns", cnt_ns, 8'd5);
        check("ped_short_cnt_ew", cnt_ew, 8'd9);
        check("ped_short_wait", ped_wait, 1'b0);
        next_sec(4);
        check("ped_short_last_sec", cnt_ns, 8'd1);
        check("ped_short_still_grn", light_ns, 3'b001);
        next_sec(1);
        check("ped_short_yellow", light_ns, 3'b010);

        // Request during NS yellow is held for EW green
        pulse_ped();
        check("ped_yel_wait", ped_wait, 1'b1);
        check("ped_yel_cnt_ns", cnt_ns, 8'd3);
        next_sec(3);
        check("ped_allred_wait", ped_wait, 1'b1);
        next_sec(1);
        check("ped_ew_light", light_ew, 3'b001);
        check("ped_ew_cnt_ew", cnt_ew, 8'd5);
        check("ped_ew_cnt_ns", cnt_ns, 8'd9);
        check("ped_ew_wait", ped_wait, 1'b0);
        next_sec(5);
        check("ped_ew_yellow", light_ew, 3'b010);

        // Request coincident with the final tick of NS green
        next_sec(3);
        next_sec(1);
        check("coinc_ns_green", cnt_ns, 8'd20);
        next_sec(19);
        check("coinc_last_sec", cnt_ns, 8'd1);
        wait_tick();
        pulse_ped();
        check("coinc_ns_yellow", light_ns, 3'b010);
        check("coinc_cnt_ns", cnt_ns, 8'd3);
        check("coinc_wait", ped_wait, 1'b1);
        next_sec(4);
        check("coinc_ew_cnt", cnt_ew, 8'd5);
        check("coinc_ew_wait", ped_wait, 1'b0);

        // Asynchronous reset mid EW green
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_light_ns", light_ns, 3'b100);
        check("arst_light_ew", light_ew, 3'b100);
        check("arst_cnt_ns", cnt_ns, 8'd1);
        check("arst_cnt_ew", cnt_ew, 8'd25);
        check("arst_tick", tick_1s, 1'b0);
        repeat (2) @(posedge clk);
        do_reset_release();
        check_first_tick();

`ifdef TRAFFIC_NIGHT_FLASH_EN
        cycle();
        night = 1'b1;
        cycle();
        check("flash_ns_on", light_ns, 3'b010);
        check("flash_ew_on", light_ew, 3'b010);
        check("flash_cnt_ns", cnt_ns, 8'd0);
        check("flash_cnt_ew", cnt_ew, 8'd0);
        next_sec(1);
        check("flash_ns_off", light_ns, 3'b000);
        check("flash_ew_off", light_ew, 3'b000);
        pulse_ped();
        check("flash_ped_ignored", ped_wait, 1'b0);
        next_sec(1);
        check("flash_ns_on2", light_ns, 3'b010);
        night = 1'b0;
        cycle();
        check("flash_exit_ns", light_ns, 3'b100);
        check("flash_exit_ew", light_ew, 3'b100);
        check("flash_exit_cnt_ns", cnt_ns, 8'd1);
        check("flash_exit_cnt_ew", cnt_ew, 8'd25);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
